ram_dump_reader: RTL and testbench
==================================

// Module: ram_dump_reader
// PURPOSE
//  Read-back counterpart of the file-to-RAM loader: walks a word range of basic_ram via the
//  cs/we/oe/data_size/mem_done protocol and streams each word out over a valid/ready port.
//  Shares the RAM port mux with the loader and the core. Used by benches to dump memory after a run.
// PARAMETERS
//  ADDR_W       32   RAM byte-address width
//  DATA_W       32   RAM data width
//  CNT_W        16   width of word_count / remaining counter
//  TIMEOUT_CYC  255  max cycles waiting for ram_ready before abort (must be >= 1)
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset, synchronous, active-high
//  start          in   1       pulse: begin dump (ignored while busy)
//  base_addr      in   ADDR_W  first byte address (word aligned; low 2 bits ignored)
//  word_count     in   CNT_W   number of words to read
//  busy           out  1       high from accepted start until DONE
//  finished       out  1       high in DONE; held until next accepted start
//  timeout_err    out  1       sticky: dump aborted on missing ram_ready; cleared by start
//  ram_addr       out  ADDR_W  RAM address
//  ram_d_in       out  DATA_W  RAM write data; constant 0
//  ram_cs         out  1       RAM chip select
//  ram_we         out  1       RAM write enable; constant 0
//  ram_oe         out  1       RAM output enable
//  ram_data_size  out  2       transfer size; constant 2'b11 (word)
//  ram_d_out      in   DATA_W  RAM read data
//  ram_ready      in   1       RAM mem_done
//  out_valid      out  1       out_data/out_addr valid
//  out_ready      in   1       sink accepts word
//  out_data       out  DATA_W  word read
//  out_addr       out  ADDR_W  address of out_data
//  checksum       out  DATA_W  running sum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; busy, finished, timeout_err, ram_cs, ram_oe, out_valid = 0;
//    ram_addr, out_data, out_addr, checksum = 0. Reset mid-dump aborts at once, no RAM access completes.
//  - FSM IDLE -> REQ -> WAIT -> OUT -> (REQ | DONE); DONE -> REQ/DONE on start.
//  - IDLE/DONE: start=1 latches base_addr & ~3, word_count; clears finished, timeout_err, checksum.
//    word_count==0 -> DONE next cycle (finished=1, no RAM access). Else REQ next cycle.
//  - REQ (1 cycle): ram_cs=ram_oe=1, ram_addr=current addr; -> WAIT. cs/oe stay high through WAIT.
//  - WAIT: on ram_ready=1 capture ram_d_out into out_data, addr into out_addr, drop cs/oe next cycle,
//    -> OUT. Latency: ram_ready in cycle N -> out_valid=1 in cycle N+1.
//  - WAIT timeout: TIMEOUT_CYC cycles in WAIT without ram_ready -> timeout_err=1, cs/oe=0, -> DONE.
//  - OUT: out_valid=1, out_data/out_addr stable until out_valid&&out_ready; on that cycle decrement
//    remaining, addr += 4 (wraps mod 2^ADDR_W); remaining==0 -> DONE else REQ. No RAM access in OUT.
//  - start while busy: ignored. ram_ready outside WAIT: ignored.
//  - finished=1 in DONE only; busy = state not in {IDLE, DONE}.
// CONFIGURATION
//  - Macro DUMP_CHECKSUM_EN defined: checksum = sum mod 2^DATA_W of all words accepted by the sink
//    since last start; updates the cycle after each out handshake.
//  - Not defined: checksum tied to 0, no adder synthesised. Port present in both builds.
// STRUCTURE
//  - Shared package mem_if_pkg: data_size encodings (SZ_BYTE 2'b00, SZ_HALF 2'b01, SZ_WORD 2'b11),
//    WORD_STRIDE=4, dump FSM state enum.
//  - One sub-module: ram_wait_timer (loadable down-counter, expired flag) for the WAIT timeout.
// TESTING
//  - base_addr=0x100, word_count=4, RAM preloaded 0x11,0x22,0x33,0x44, out_ready=1 -> out_addr
//    0x100,0x104,0x108,0x10C with matching data; finished=1; checksum=0xAA (with DUMP_CHECKSUM_EN).
//  - word_count=0, start -> finished=1 next cycle, ram_cs never asserted, out_valid never asserted.
//  - out_ready low 10 cycles on word 2 -> out_data/out_addr stable, no new ram_cs until accepted.
//  - ram_ready forced 0, TIMEOUT_CYC=8 -> timeout_err=1 after 8 WAIT cycles, finished=1, cs/oe=0.
//  - base_addr=0xFFFFFFFC, word_count=2 -> addrs 0xFFFFFFFC then 0x00000000.
//  - rst asserted in WAIT -> next cycle all outputs at reset values; second start during busy ignored.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the basic_ram port protocol and the dump reader FSM.
// Contents: data_size encodings, word stride in bytes, dump FSM state enum.
// Imported by ram_dump_reader and its timer.
package mem_if_pkg;

    // data_size encodings on the RAM port
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // byte distance between consecutive words
    localparam int WORD_STRIDE = 4;

    typedef enum logic [2:0] {
        DS_IDLE = 3'd0,
        DS_REQ  = 3'd1,
        DS_WAIT = 3'd2,
        DS_OUT  = 3'd3,
        DS_DONE = 3'd4
    } dump_state_t;

endpackage

// File: rtl/ram_wait_timer.sv
// Purpose: loadable down-counter that flags when a RAM wait has run out of budget.
// Latency: load takes effect next cycle; expired is a combinational decode of the count.
// Backpressure: none; counts while en is high and holds at zero.
// Ports: clk, rst (sync active-high), load/load_val (preset), en (count), expired (count == 0).
module ram_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/ram_dump_reader.sv
// Purpose: walks a word range of basic_ram (cs/we/oe/data_size/mem_done) and streams words out on valid/ready.
// Latency: ram_ready in cycle N -> out_valid in cycle N+1; one REQ cycle precedes each RAM wait.
// Backpressure: out_valid holds data/addr until out_ready; no new RAM request is issued while stalled.
// Ports: clk, rst (sync active-high); start/base_addr/word_count control; busy/finished/timeout_err status;
//        ram_* RAM master port; out_valid/out_ready/out_data/out_addr stream; checksum.
// Build option: define DUMP_CHECKSUM_EN to enable the running checksum of accepted words (else tied to 0).
module ram_dump_reader
    import mem_if_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              finished,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [1:0]        ram_data_size,
    input  logic [DATA_W-1:0] ram_d_out,
    input  logic              ram_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] checksum
);

    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    // Timer is preset in REQ so that it reads zero on the last allowed WAIT cycle.
    localparam logic [TW-1:0] TIMER_PRESET = TW'(TIMEOUT_CYC - 1);

    dump_state_t       state, state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] data_addr_q;
    logic              timeout_q;

    logic accept_start;
    logic take_word;
    logic handshake;
    logic abort;
    logic timer_load;
    logic timer_en;
    logic timer_expired;

    ram_wait_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (TIMER_PRESET),
        .en       (timer_en),
        .expired  (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        accept_start = 1'b0;
        take_word    = 1'b0;
        handshake    = 1'b0;
        abort        = 1'b0;
        timer_load   = 1'b0;
        timer_en     = 1'b0;
        case (state)
            DS_IDLE, DS_DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_nxt    = (word_count == '0) ? DS_DONE : DS_REQ;
                end
            end
            DS_REQ: begin
                timer_load = 1'b1;
                state_nxt  = DS_WAIT;
            end
            DS_WAIT: begin
                // A late ram_ready on the final budget cycle still counts as a hit.
                if (ram_ready) begin
                    take_word = 1'b1;
                    state_nxt = DS_OUT;
                end else if (timer_expired) begin
                    abort     = 1'b1;
                    state_nxt = DS_DONE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            DS_OUT: begin
                if (out_ready) begin
                    handshake = 1'b1;
                    state_nxt = (remaining == CNT_W'(1)) ? DS_DONE : DS_REQ;
                end
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr        <= '0;
            remaining   <= '0;
            data_q      <= '0;
            data_addr_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            if (accept_start) begin
                addr      <= {base_addr[ADDR_W-1:2], 2'b00};
                remaining <= word_count;
                timeout_q <= 1'b0;
            end
            if (take_word) begin
                data_q      <= ram_d_out;
                data_addr_q <= addr;
            end
            if (handshake) begin
                remaining <= remaining - 1'b1;
                addr      <= addr + ADDR_W'(WORD_STRIDE);
            end
            if (abort) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (accept_start) begin
            sum_q <= '0;
        end else if (handshake) begin
            sum_q <= sum_q + data_q;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    // cs/oe span REQ and WAIT so the RAM sees one continuous access per word.
    assign ram_cs        = (state == DS_REQ) || (state == DS_WAIT);
    assign ram_oe        = ram_cs;
    assign ram_we        = 1'b0;
    assign ram_d_in      = '0;
    assign ram_data_size = SZ_WORD;
    assign ram_addr      = addr;

    assign busy        = (state == DS_REQ) || (state == DS_WAIT) || (state == DS_OUT);
    assign finished    = (state == DS_DONE);
    assign timeout_err = timeout_q;
    assign out_valid   = (state == DS_OUT);
    assign out_data    = data_q;
    assign out_addr    = data_addr_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
module tb_ram_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy, finished, timeout_err;
    logic [31:0] ram_addr, ram_d_in, ram_d_out;
    logic        ram_cs, ram_we, ram_oe, ram_ready;
    logic [1:0]  ram_data_size;
    logic        out_valid, out_ready;
    logic [31:0] out_data, out_addr, checksum;

    always #5 clk = ~clk;

    ram_dump_reader #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(16), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .finished(finished), .timeout_err(timeout_err),
        .ram_addr(ram_addr), .ram_d_in(ram_d_in), .ram_cs(ram_cs), .ram_we(ram_we),
        .ram_oe(ram_oe), .ram_data_size(ram_data_size), .ram_d_out(ram_d_out),
        .ram_ready(ram_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .checksum(checksum)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // RAM contents: four known words at 0x100, everything else the inverted address.
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h100: ram_word = 32'h11;
            32'h104: ram_word = 32'h22;
            32'h108: ram_word = 32'h33;
            32'h10C: ram_word = 32'h44;
            default: ram_word = ~a;
        endcase
    endfunction

    // RAM responder: answers after ram_lat cycles of cs&oe, silent when ram_en is low.
    int ram_lat = 0;
    bit ram_en  = 1'b1;
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (ram_cs && ram_oe && ram_en && !rst) begin
            if (wait_cnt >= ram_lat) begin
                ram_ready = 1'b1;
                ram_d_out = ram_word(ram_addr);
            end else begin
                ram_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            ram_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Sink monitor: records handshakes and counts cs / out_valid cycles.
    logic [31:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int cs_cycles = 0;
    int ov_cycles = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_cs) cs_cycles++;
            if (out_valid) ov_cycles++;
            if (out_valid && out_ready) begin
                cap_addr.push_back(out_addr);
                cap_data.push_back(out_data);
            end
        end
    end

    task automatic do_start(input logic [31:0] b, input logic [15:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (finished) break;
            @(negedge clk);
        end
        n_cmp++;
        if (!finished) begin
            n_fail++;
            $display("FAIL %s: finished not seen within %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        logic [15:0] cnt;
        int          lat;
        logic [31:0] first_addr;
        logic [31:0] last_addr;
        logic [31:0] sum;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int h0, cs0, ov0;
        logic [31:0] hold_d, hold_a, exp_sum;
        int bad;

        vecs[0] = '{32'h0000_0100, 16'd4, 0, 32'h0000_0100, 32'h0000_010C, 32'h0000_00AA};
        vecs[1] = '{32'h0000_0103, 16'd2, 1, 32'h0000_0100, 32'h0000_0104, 32'h0000_0033};
        vecs[2] = '{32'hFFFF_FFFC, 16'd2, 3, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0002};
        vecs[3] = '{32'h0000_0200, 16'd1, 2, 32'h0000_0200, 32'h0000_0200, 32'hFFFF_FDFF};

        rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b0;
        ram_ready = 1'b0; ram_d_out = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset finished", {31'd0, finished}, 32'd0);
        check("reset cs", {31'd0, ram_cs}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset ram_addr", ram_addr, 32'd0);
        check("reset checksum", checksum, 32'd0);
        check("const we/size/d_in", {ram_d_in[29:0], ram_we, ram_data_size[0]}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven dumps with a free-running sink.
        out_ready = 1'b1;
        for (int v = 0; v < 4; v++) begin
            ram_lat = vecs[v].lat;
            h0 = cap_addr.size();
            do_start(vecs[v].base, vecs[v].cnt);
            wait_done($sformatf("vec%0d done", v), 100);
            check($sformatf("vec%0d words", v), 32'(cap_addr.size() - h0), 32'(vecs[v].cnt));
            for (int i = 0; i < int'(vecs[v].cnt); i++) begin
                if (h0 + i < cap_addr.size()) begin
                    check($sformatf("vec%0d addr%0d", v, i), cap_addr[h0+i], vecs[v].first_addr + 32'(4*i));
                    check($sformatf("vec%0d data%0d", v, i), cap_data[h0+i], ram_word(vecs[v].first_addr + 32'(4*i)));
                end
            end
            if (cap_addr.size() > h0)
                check($sformatf("vec%0d last addr", v), cap_addr[cap_addr.size()-1], vecs[v].last_addr);
            check($sformatf("vec%0d busy", v), {31'd0, busy}, 32'd0);
            check($sformatf("vec%0d timeout_err", v), {31'd0, timeout_err}, 32'd0);
`ifdef DUMP_CHECKSUM_EN
            exp_sum = vecs[v].sum;
`else
            exp_sum = 32'd0;
`endif
            check($sformatf("vec%0d checksum", v), checksum, exp_sum);
        end

        // Zero-length dump: finished next cycle, no RAM or output activity.
        cs0 = cs_cycles; ov0 = ov_cycles;
        do_start(32'h300, 16'd0);
        check("zero finished", {31'd0, finished}, 32'd1);
        check("zero busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("zero cs cycles", 32'(cs_cycles - cs0), 32'd0);
        check("zero valid cycles", 32'(ov_cycles - ov0), 32'd0);
        check("zero checksum", checksum, 32'd0);

        // Backpressure: word 2 held for 10 cycles with out_ready low.
        out_ready = 1'b0; ram_lat = 1;
        h0 = cap_addr.size();
        do_start(32'h100, 16'd4);
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 50; i++) begin
                if (out_valid) break;
                @(negedge clk);
            end
            check($sformatf("bp valid w%0d", w), {31'd0, out_valid}, 32'd1);
            if (w == 2) begin
                hold_d = out_data; hold_a = out_addr; cs0 = cs_cycles; bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (!out_valid || out_data !== hold_d || out_addr !== hold_a) bad++;
                end
                check("bp stable cycles bad", 32'(bad), 32'd0);
                check("bp no cs while stalled", 32'(cs_cycles - cs0), 32'd0);
                check("bp held addr", out_addr, 32'h108);
                check("bp held data", out_data, 32'h33);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        wait_done("bp done", 50);
        check("bp words", 32'(cap_addr.size() - h0), 32'd4);
`ifdef DUMP_CHECKSUM_EN
        check("bp checksum", checksum, 32'hAA);
`else
        check("bp checksum", checksum, 32'h0);
`endif

        // Timeout: RAM never answers; REQ + 8 WAIT cycles of cs, then DONE.
        ram_en = 1'b0; out_ready = 1'b1;
        cs0 = cs_cycles; ov0 = ov_cycles;
        do_start(32'h100, 16'd3);
        wait_done("to done", 50);
        check("to timeout_err", {31'd0, timeout_err}, 32'd1);
        check("to cs", {31'd0, ram_cs}, 32'd0);
        check("to oe", {31'd0, ram_oe}, 32'd0);
        check("to cs cycles", 32'(cs_cycles - cs0), 32'd9);
        check("to valid cycles", 32'(ov_cycles - ov0), 32'd0);
        ram_en = 1'b1;

        // Reset in WAIT returns every output to its reset value next cycle.
        ram_lat = 6;
        do_start(32'h100, 16'd2);
        check("rst pre timeout cleared", {31'd0, timeout_err}, 32'd0);
        @(negedge clk);
        check("rst pre cs in wait", {31'd0, ram_cs}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst cs/oe", {30'd0, ram_cs, ram_oe}, 32'd0);
        check("rst valid/fin/err", {29'd0, out_valid, finished, timeout_err}, 32'd0);
        check("rst ram_addr", ram_addr, 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_addr", out_addr, 32'd0);
        check("rst checksum", checksum, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Second start while busy is ignored.
        ram_lat = 1; out_ready = 1'b1;
        h0 = cap_addr.size();
        do_start(32'h100, 16'd2);
        @(negedge clk);
        do_start(32'h200, 16'd5);
        wait_done("busy start done", 60);
        check("busy start words", 32'(cap_addr.size() - h0), 32'd2);
        if (cap_addr.size() >= h0 + 2) begin
            check("busy start addr0", cap_addr[h0], 32'h100);
            check("busy start addr1", cap_addr[h0+1], 32'h104);
            check("busy start data1", cap_data[h0+1], 32'h22);
        end
        repeat (3) @(negedge clk);
        check("busy start stays done", {31'd0, finished}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
